// File: rtl/carregador_programa.sv
// carregador_programa: copies a program image from the HD into instruction
// memory one word at a time, with a read handshake per word, a per-word
// timeout and a destination range check done before any traffic starts.
module carregador_programa #(
  parameter int MEM_DEPTH = 201,
  parameter int TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        ehSO,
  input  logic [31:0] hdBase,
  input  logic [31:0] destBase,
  input  logic [31:0] numPalavras,
  input  logic [31:0] hdDado,
  input  logic        hdValido,
  output logic        hdLer,
  output logic [31:0] hdEndereco,
  output logic        memEscreve,
  output logic [31:0] memEndereco,
  output logic [31:0] memDado,
  output logic        ocupado,
  output logic        concluido,
  output logic        erro,
  output logic        encerrarBios
);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    PEDE   = 3'd1,
    ESPERA = 3'd2,
    GRAVA  = 3'd3,
    FIM    = 3'd4,
    ERRO   = 3'd5
  } estado_t;

  estado_t     estado_reg, estado_next;
  logic [31:0] base_reg, base_next;
  logic [31:0] dest_reg, dest_next;
  logic [31:0] n_reg, n_next;
  logic        so_reg, so_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [7:0]  esp_reg, esp_next;
  logic [31:0] hd_end_reg, hd_end_next;
  logic [31:0] mem_end_reg, mem_end_next;
  logic [31:0] mem_dado_reg, mem_dado_next;
  logic        erro_reg, erro_next;

  // 33-bit end address so that a wrapping destBase+numPalavras is never in range
  logic [32:0] fim_destino;
  logic [31:0] cnt_inc;

  assign fim_destino = {1'b0, destBase} + {1'b0, numPalavras};
  assign cnt_inc     = cnt_reg + 32'd1;

  // Next-state and next-register values; every register holds by default
  always_comb begin
    estado_next   = estado_reg;
    base_next     = base_reg;
    dest_next     = dest_reg;
    n_next        = n_reg;
    so_next       = so_reg;
    cnt_next      = cnt_reg;
    esp_next      = esp_reg;
    hd_end_next   = hd_end_reg;
    mem_end_next  = mem_end_reg;
    mem_dado_next = mem_dado_reg;
    erro_next     = erro_reg;
    case (estado_reg)
      OCIOSO: begin
        if (start) begin
          if (numPalavras == 32'd0) begin
            so_next     = ehSO;
            erro_next   = 1'b0;
            estado_next = FIM;
          end else if (fim_destino > 33'(MEM_DEPTH)) begin
            erro_next   = 1'b1;
            estado_next = ERRO;
          end else begin
            base_next   = hdBase;
            dest_next   = destBase;
            n_next      = numPalavras;
            so_next     = ehSO;
            cnt_next    = 32'd0;
            erro_next   = 1'b0;
            hd_end_next = hdBase;
            estado_next = PEDE;
          end
        end
      end
      PEDE: begin
        esp_next    = 8'd0;
        estado_next = ESPERA;
      end
      ESPERA: begin
        if (hdValido) begin
          mem_dado_next = hdDado;
          mem_end_next  = dest_reg + cnt_reg;
          estado_next   = GRAVA;
        end else if (esp_reg == 8'(TIMEOUT)) begin
          // erro becomes visible together with the ERRO state
          erro_next   = 1'b1;
          estado_next = ERRO;
        end else begin
          esp_next = esp_reg + 8'd1;
        end
      end
      GRAVA: begin
        cnt_next = cnt_inc;
        if (cnt_inc == n_reg) begin
          estado_next = FIM;
        end else begin
          hd_end_next = base_reg + cnt_inc;
          estado_next = PEDE;
        end
      end
      FIM: begin
        estado_next = OCIOSO;
      end
      ERRO: begin
        erro_next   = 1'b1;
        estado_next = OCIOSO;
      end
      default: begin
        estado_next = OCIOSO;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg   <= OCIOSO;
      base_reg     <= 32'd0;
      dest_reg     <= 32'd0;
      n_reg        <= 32'd0;
      so_reg       <= 1'b0;
      cnt_reg      <= 32'd0;
      esp_reg      <= 8'd0;
      hd_end_reg   <= 32'd0;
      mem_end_reg  <= 32'd0;
      mem_dado_reg <= 32'd0;
      erro_reg     <= 1'b0;
    end else begin
      estado_reg   <= estado_next;
      base_reg     <= base_next;
      dest_reg     <= dest_next;
      n_reg        <= n_next;
      so_reg       <= so_next;
      cnt_reg      <= cnt_next;
      esp_reg      <= esp_next;
      hd_end_reg   <= hd_end_next;
      mem_end_reg  <= mem_end_next;
      mem_dado_reg <= mem_dado_next;
      erro_reg     <= erro_next;
    end
  end

  // Strobes are decoded straight from the state register
  assign hdLer        = (estado_reg == PEDE);
  assign memEscreve   = (estado_reg == GRAVA);
  assign ocupado      = (estado_reg != OCIOSO);
  assign concluido    = (estado_reg == FIM);
  assign encerrarBios = (estado_reg == FIM) && so_reg;
  assign hdEndereco   = hd_end_reg;
  assign memEndereco  = mem_end_reg;
  assign memDado      = mem_dado_reg;
  assign erro         = erro_reg;

endmodule

// File: tb/tb_carregador_programa.sv
// tb_carregador_programa: directed loads against a timeline model of the
// loader; expected per-cycle outputs are laid out from the word schedule.
module tb_carregador_programa;
  localparam int MAXC = 2048;
  localparam int MEMD = 201;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ehSO = 1'b0;
  logic        hdValido = 1'b0;
  logic [31:0] hdBase = '0, destBase = '0, numPalavras = '0, hdDado = '0;
  logic        hdLer, memEscreve, ocupado, concluido, erro, encerrarBios;
  logic [31:0] hdEndereco, memEndereco, memDado;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // expected timeline, indexed by cycle number (cycle c follows posedge c)
  bit          e_ler [MAXC];
  bit          e_wr  [MAXC];
  bit          e_ocu [MAXC];
  bit          e_fim [MAXC];
  bit          e_enc [MAXC];
  bit          e_erro[MAXC];
  bit          e_hdav[MAXC];
  bit          e_z   [MAXC];
  logic [31:0] e_hda [MAXC];
  logic [31:0] e_mema[MAXC];
  logic [31:0] e_memd[MAXC];
  // HD response schedule
  bit          d_val [MAXC];
  logic [31:0] d_dat [MAXC];

  int          dly[8];
  logic [31:0] dat[8];

  // observed events for the literal pins
  logic [31:0] q_hda[$], q_wa[$], q_wd[$];
  int          q_ler[$], q_fim[$];
  int          enc_cnt = 0;
  int          erro_rise = -1;
  logic        erro_q = 1'b0;

  carregador_programa dut (
    .clock(clock), .reset(reset), .start(start), .ehSO(ehSO),
    .hdBase(hdBase), .destBase(destBase), .numPalavras(numPalavras),
    .hdDado(hdDado), .hdValido(hdValido), .hdLer(hdLer),
    .hdEndereco(hdEndereco), .memEscreve(memEscreve),
    .memEndereco(memEndereco), .memDado(memDado), .ocupado(ocupado),
    .concluido(concluido), .erro(erro), .encerrarBios(encerrarBios)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (cyc >= MAXC - 4) begin
      $display("FAIL watchdog cyc=%0d limit=%0d", cyc, MAXC - 4);
      $fatal(1, "cycle budget exhausted");
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // HD model: presents data only in scheduled cycles, junk otherwise
  always @(negedge clock) begin
    hdValido = d_val[cyc];
    hdDado   = d_val[cyc] ? d_dat[cyc] : (32'hDEAD0000 | 32'(cyc));
  end

  // Cycle-by-cycle comparison against the timeline
  always @(negedge clock) begin
    chk("hdLer", 32'(hdLer), 32'(e_ler[cyc]));
    chk("memEscreve", 32'(memEscreve), 32'(e_wr[cyc]));
    chk("ocupado", 32'(ocupado), 32'(e_ocu[cyc]));
    chk("concluido", 32'(concluido), 32'(e_fim[cyc]));
    chk("encerrarBios", 32'(encerrarBios), 32'(e_enc[cyc]));
    chk("erro", 32'(erro), 32'(e_erro[cyc]));
    if (e_hdav[cyc]) chk("hdEndereco", hdEndereco, e_hda[cyc]);
    if (e_wr[cyc]) begin
      chk("memEndereco", memEndereco, e_mema[cyc]);
      chk("memDado", memDado, e_memd[cyc]);
    end
    if (e_z[cyc]) begin
      chk("hdEndereco_rst", hdEndereco, 32'd0);
      chk("memEndereco_rst", memEndereco, 32'd0);
      chk("memDado_rst", memDado, 32'd0);
    end
  end

  // Event recorder
  always @(negedge clock) begin
    if (hdLer) begin
      q_hda.push_back(hdEndereco);
      q_ler.push_back(cyc);
    end
    if (memEscreve) begin
      q_wa.push_back(memEndereco);
      q_wd.push_back(memDado);
    end
    if (concluido) q_fim.push_back(cyc);
    if (encerrarBios) enc_cnt++;
    if (erro && !erro_q) erro_rise = cyc;
    erro_q = erro;
  end

  task automatic clear_mon();
    q_hda.delete(); q_wa.delete(); q_wd.delete();
    q_ler.delete(); q_fim.delete();
    enc_cnt = 0;
    erro_rise = -1;
  endtask

  task automatic set_erro(input int c, input bit v);
    for (int x = c; x < MAXC; x++) e_erro[x] = v;
  endtask

  task automatic clear_from(input int c);
    for (int x = c; x < MAXC; x++) begin
      e_ler[x] = 0; e_wr[x] = 0; e_ocu[x] = 0; e_fim[x] = 0; e_enc[x] = 0;
      e_erro[x] = 0; e_hdav[x] = 0; d_val[x] = 0;
    end
  endtask

  // Lay out the expected outputs of a load whose start is sampled at edge k.
  // A negative dly entry means the HD never answers that word.
  task automatic plan_load(input int k, input logic [31:0] hb, input logic [31:0] db,
                           input logic [31:0] np, input bit so, output int endc);
    logic [32:0] top;
    int p;
    top = {1'b0, db} + {1'b0, np};
    if (np == 32'd0) begin
      e_ocu[k] = 1; e_fim[k] = 1; e_enc[k] = so;
      set_erro(k, 0);
      endc = k;
    end else if (top > 33'(MEMD)) begin
      e_ocu[k] = 1;
      set_erro(k, 1);
      endc = k;
    end else begin
      set_erro(k, 0);
      p = k;
      endc = -1;
      for (int i = 0; i < int'(np); i++) begin
        e_ler[p] = 1; e_hdav[p] = 1; e_hda[p] = hb + 32'(i);
        if (dly[i] < 0) begin
          for (int c = p + 1; c <= p + 256; c++) begin
            e_hdav[c] = 1; e_hda[c] = hb + 32'(i);
          end
          set_erro(p + 257, 1);
          endc = p + 257;
          break;
        end
        for (int c = p + 1; c <= p + 1 + dly[i]; c++) begin
          e_hdav[c] = 1; e_hda[c] = hb + 32'(i);
        end
        d_val[p + 1 + dly[i]] = 1;
        d_dat[p + 1 + dly[i]] = dat[i];
        e_wr[p + 2 + dly[i]]   = 1;
        e_mema[p + 2 + dly[i]] = db + 32'(i);
        e_memd[p + 2 + dly[i]] = dat[i];
        p = p + 3 + dly[i];
      end
      if (endc < 0) begin
        e_fim[p] = 1; e_enc[p] = so;
        endc = p;
      end
      for (int c = k; c <= endc; c++) e_ocu[c] = 1;
    end
  endtask

  // Issue one start and ride it out; with busy set, start is held high with
  // unrelated arguments in every cycle the loader is occupied.
  task automatic do_load(input logic [31:0] hb, input logic [31:0] db, input logic [31:0] np,
                         input bit so, input bit busy, output int k);
    int endc;
    @(negedge clock);
    k = cyc + 1;
    plan_load(k, hb, db, np, so, endc);
    $display("load hdBase=%0d destBase=%h n=%0d so=%0d busy=%0d start_edge=%0d end=%0d",
             hb, db, np, so, busy, k, endc);
    start = 1; hdBase = hb; destBase = db; numPalavras = np; ehSO = so;
    do begin
      @(negedge clock);
      if (busy && cyc <= endc) begin
        start = 1; hdBase = 32'h5000 + 32'(cyc); destBase = 32'(cyc);
        numPalavras = 32'(cyc % 3); ehSO = ~so;
      end else begin
        start = 0; hdBase = '0; destBase = '0; numPalavras = '0; ehSO = 0;
      end
    end while (cyc <= endc);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int k, r, endc;
    for (int c = 0; c <= 3; c++) e_z[c] = 1;
    while (cyc < 3) @(negedge clock);
    #2 reset = 1'b1;

    // 3-word OS load, immediate HD answers
    clear_mon();
    for (int i = 0; i < 3; i++) begin dly[i] = 0; dat[i] = 32'hA0 + 32'(i); end
    do_load(32'd100, 32'd0, 32'd3, 1'b1, 1'b0, k);
    chk("t1_nfim", 32'(q_fim.size()), 32'd1);
    if (q_fim.size() == 1) chk("t1_fim_lat", 32'(q_fim[0] - k), 32'd9);
    chk("t1_enc", 32'(enc_cnt), 32'd1);
    chk("t1_nwr", 32'(q_wa.size()), 32'd3);
    if (q_wa.size() == 3) begin
      chk("t1_wa2", q_wa[2], 32'd2);
      chk("t1_wd0", q_wd[0], 32'hA0);
      chk("t1_wd2", q_wd[2], 32'hA2);
    end
    if (q_hda.size() == 3) chk("t1_hda1", q_hda[1], 32'd101);
    else chk("t1_nler", 32'(q_hda.size()), 32'd3);

    // 4-word load cut by reset during the second word
    clear_mon();
    for (int i = 0; i < 4; i++) begin dly[i] = 0; dat[i] = 32'hC0 + 32'(i); end
    @(negedge clock);
    k = cyc + 1;
    plan_load(k, 32'd200, 32'd4, 32'd4, 1'b0, endc);
    $display("load hdBase=200 destBase=4 n=4 so=0 start_edge=%0d reset_in_cycle=%0d", k, k + 4);
    start = 1; hdBase = 32'd200; destBase = 32'd4; numPalavras = 32'd4;
    @(negedge clock);
    start = 0; hdBase = '0; destBase = '0; numPalavras = '0;
    while (cyc < k + 4) @(negedge clock);
    r = cyc;
    #2 reset = 1'b0;
    clear_from(r + 1);
    for (int c = r + 1; c <= r + 5; c++) e_z[c] = 1;
    #1;
    chk("rst_hdLer", 32'(hdLer), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_memEscreve", 32'(memEscreve), 32'd0);
    chk("rst_hdEndereco", hdEndereco, 32'd0);
    while (cyc < r + 3) @(negedge clock);
    #2 reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst_nwr", 32'(q_wa.size()), 32'd1);
    chk("rst_nfim", 32'(q_fim.size()), 32'd0);

    // variable HD latency, application image
    clear_mon();
    dly[0] = 0; dly[1] = 5; dly[2] = 17;
    for (int i = 0; i < 3; i++) dat[i] = 32'hB0 + 32'(i);
    do_load(32'd100, 32'd0, 32'd3, 1'b0, 1'b0, k);
    chk("lat_enc", 32'(enc_cnt), 32'd0);
    if (q_fim.size() == 1) chk("lat_fim_lat", 32'(q_fim[0] - k), 32'd31);
    else chk("lat_nfim", 32'(q_fim.size()), 32'd1);

    // HD silence -> timeout, then a late hdValido that must be ignored
    clear_mon();
    dly[0] = -1; dly[1] = 0; dat[0] = 32'h11; dat[1] = 32'h22;
    do_load(32'd40, 32'd20, 32'd2, 1'b0, 1'b0, k);
    d_val[cyc + 1] = 1; d_dat[cyc + 1] = 32'h77;
    repeat (4) @(negedge clock);
    chk("to_nwr", 32'(q_wa.size()), 32'd0);
    if (q_ler.size() == 1) chk("to_lat", 32'(erro_rise - q_ler[0]), 32'd257);
    else chk("to_nler", 32'(q_ler.size()), 32'd1);

    // destination range checks
    clear_mon();
    do_load(32'd0, 32'd198, 32'd4, 1'b0, 1'b0, k);
    chk("bnd_nler", 32'(q_ler.size()), 32'd0);
    chk("bnd_nwr", 32'(q_wa.size()), 32'd0);
    clear_mon();
    for (int i = 0; i < 4; i++) begin dly[i] = i; dat[i] = 32'hD0 + 32'(i); end
    do_load(32'd7, 32'd197, 32'd4, 1'b0, 1'b0, k);
    if (q_wa.size() == 4) chk("bnd_last", q_wa[3], 32'd200);
    else chk("bnd_nwr2", 32'(q_wa.size()), 32'd4);
    chk("bnd_erro", 32'(erro), 32'd0);

    // wrapping range, then a zero-length load
    clear_mon();
    do_load(32'd0, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, k);
    chk("wrap_erro", 32'(erro), 32'd1);
    clear_mon();
    do_load(32'd9, 32'd3, 32'd0, 1'b1, 1'b0, k);
    chk("zero_nler", 32'(q_ler.size()), 32'd0);
    chk("zero_nwr", 32'(q_wa.size()), 32'd0);
    if (q_fim.size() == 1) chk("zero_fim_lat", 32'(q_fim[0] - k), 32'd0);
    else chk("zero_nfim", 32'(q_fim.size()), 32'd1);

    // start hammered in every busy state
    clear_mon();
    dly[0] = 2; dly[1] = 0; dly[2] = 1;
    for (int i = 0; i < 3; i++) dat[i] = 32'hE0 + 32'(i);
    do_load(32'd300, 32'd10, 32'd3, 1'b1, 1'b1, k);
    chk("busy_nwr", 32'(q_wa.size()), 32'd3);
    if (q_hda.size() == 3) chk("busy_hda2", q_hda[2], 32'd302);
    chk("busy_enc", 32'(enc_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Sequencer that copies a program image from the HD into the instruction memory, word by word, on command from the BIOS/OS datapath. It drives the instruction-memory write port and write address directly, handshakes each read with the HD, and bounds-checks the destination range. When the loaded image is the OS, it emits the end-of-BIOS pulse.

## Interface
- `MEM_DEPTH`, 201: number of instruction-memory words; valid addresses are 0..MEM_DEPTH-1.
- `TIMEOUT`, 255: maximum cycles spent waiting for `hdValido` on a single word.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; forces the reset state below immediately.
- `start` in 1: load request, sampled only in OCIOSO.
- `ehSO` in 1: image being loaded is the OS; sampled with `start`.
- `hdBase` in 32: first HD word address; sampled with `start`.
- `destBase` in 32: first instruction-memory address; sampled with `start`.
- `numPalavras` in 32: word count; sampled with `start`.
- `hdDado` in 32: HD read data; valid when `hdValido`=1.
- `hdValido` in 1: HD read-data-valid strobe.
- `hdLer` out 1: HD read request.
- `hdEndereco` out 32: HD read address.
- `memEscreve` out 1: instruction-memory write enable, one cycle per word.
- `memEndereco` out 32: instruction-memory write address.
- `memDado` out 32: instruction-memory write data.
- `ocupado` out 1: high in every state except OCIOSO.
- `concluido` out 1: one-cycle pulse on successful completion.
- `erro` out 1: sticky error flag.
- `encerrarBios` out 1: one-cycle pulse, coincident with `concluido`, only when `ehSO` was latched.

## Operation
- All outputs are registered and decoded from state. On reset, every output is 0, the state is OCIOSO, and the internal counters and latches are 0.
- Internal state:
  - latched copies `base`, `dest`, `n`, `so`
  - 32-bit word counter `cnt`
  - 8-bit wait counter `esp`
- OCIOSO:
  - If `start`=1 with `numPalavras`=0, go to FIM.
  - If `start`=1 with `destBase`+`numPalavras` > MEM_DEPTH, go to ERRO. The sum is computed in 33 bits, so wrap-around is never treated as in range.
  - Otherwise, latch the inputs, clear `cnt` and `erro`, and go to PEDE.
- PEDE: `hdLer`=1 and `hdEndereco`=`base`+`cnt` (mod 2^32) for exactly one cycle; clear `esp`; go to ESPERA.
- ESPERA:
  - `hdEndereco` is held and `hdLer`=0.
  - If `hdValido`=1: capture `hdDado` into `memDado` and go to GRAVA.
  - Else if `esp`=TIMEOUT: go to ERRO.
  - Else: `esp`+1.
- GRAVA:
  - `memEscreve`=1, `memEndereco`=`dest`+`cnt`, `cnt`+1.
  - If `cnt`+1=`n`, go to FIM; otherwise go to PEDE.
- FIM: `concluido`=1 and `encerrarBios`=`so` for one cycle; go to OCIOSO.
- ERRO:
  - Set `erro`=1; go to OCIOSO.
  - No memory write occurs in ERRO or after entering it.
  - `erro` stays high until the next accepted `start`, including a zero-length `start`.
- `start` outside OCIOSO is ignored. `hdValido` outside ESPERA is ignored.
- Asynchronous reset mid-transfer aborts the load at once. Words already written stay in memory, and no `concluido` pulse is generated.

## Timing
- A `start` sampled at edge k gives `ocupado`=1 after k and `hdLer`=1 in cycle k+1.
- The earliest `hdValido` is the cycle after `hdLer`. With zero wait, each word takes 3 cycles (PEDE, ESPERA, GRAVA).
- An N-word load with zero HD wait: `concluido` rises 3N+1 cycles after the accepting edge and lasts 1 cycle. `ocupado` falls on the following edge.
- A zero-length load: `concluido` 1 cycle after acceptance, with no `hdLer` and no `memEscreve`.
- Timeout: with no `hdValido`, ERRO is entered after TIMEOUT+1 ESPERA cycles, and `erro`=1 one cycle after that.
- `memDado` and `memEndereco` are stable throughout the `memEscreve` cycle, so the memory can sample on either clock edge.

## Test plan
- Reset mid-run: release reset (1), start `hdBase`=100, `destBase`=0, `numPalavras`=3, `ehSO`=1, with the HD answering the next cycle with 0xA0,0xA1,0xA2 -> writes {0:0xA0,1:0xA1,2:0xA2}, `hdEndereco` 100,101,102, `concluido` and `encerrarBios` each pulse once at 10 cycles; then assert reset during the second word of a new 4-word load -> all outputs 0 immediately and no further writes.
- Variable HD latency: same 3-word load with `ehSO`=0 and `hdValido` delayed 0, 5 and 17 cycles -> data and addresses are correct, `encerrarBios` never pulses, `ocupado` stays high throughout.
- Bounds: `destBase`=198, `numPalavras`=4 -> `erro`=1, no `hdLer`, no `memEscreve`. Then `destBase`=197, `numPalavras`=4 -> success, last write at address 200, and `erro` is cleared on that accepted `start`.
- Wrap-around: `destBase`=0xFFFFFFFF, `numPalavras`=2 -> ERRO. A separate `numPalavras`=0 load -> `concluido` pulse only, with no HD or memory activity.
- Timeout: hold `hdValido`=0 after the first `hdLer` -> `erro` rises 257 cycles after `hdLer`, zero writes; a `hdValido` arriving afterwards is ignored.
- Busy: pulse `start` with new arguments in each state while a load runs -> ignored, and the original transfer completes unchanged.
